// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the bus-side memory responder and its RAM.
package mem_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BUS_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/bus_mem_responder_if.sv
// Request/response bus between the memory controller (master) and the responder (slave).
// Handshake: a request is level-sampled while bus_full is low; bus_full stays high until
// the response cycle ends, and ack pulses for one cycle when the operation completes.
interface bus_mem_responder_if;
    import mem_bus_pkg::*;

    logic                  rd_req;
    logic                  wr_req;
    logic [BUS_W-1:0]      addr;
    logic [BUS_W-1:0]      wdata;
    logic [WORD_BYTES-1:0] sel;
    logic [BUS_W-1:0]      rdata;
    logic                  bus_full;
    logic                  ack;

    modport master (
        output rd_req, wr_req, addr, wdata, sel,
        input  rdata, bus_full, ack
    );

    modport slave (
        input  rd_req, wr_req, addr, wdata, sel,
        output rdata, bus_full, ack
    );

endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sp_ram_be
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_rd_en,
    input  logic                           i_wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [BUS_W-1:0]               i_wdata,
    input  logic [WORD_BYTES-1:0]          i_sel,
    output logic [BUS_W-1:0]               o_rdata
);

    logic [BUS_W-1:0] r_mem [DEPTH_WORDS];
    logic [BUS_W-1:0] r_rdata;

    // The array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder: accepts one read/write, waits LATENCY busy cycles, commits, then acks.
module bus_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    bus_mem_responder_if.slave  bus,
    output resp_state_t         o_dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("bus_mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("bus_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
    if ((LATENCY - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("bus_mem_responder: CNT_W too narrow for LATENCY");
    end

    resp_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    op_t                   r_op;
    logic [IDX_W-1:0]      r_idx;
    logic [BUS_W-1:0]      r_wdata;
    logic [WORD_BYTES-1:0] r_sel;

    logic                  w_commit;
    logic [BUS_W-1:0]      w_rdata;

    // Write has priority over a simultaneous read; the read is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= READ;
            r_idx   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.wr_req) begin
                        r_op    <= WRITE;
                        r_idx   <= bus.addr[2 +: IDX_W];
                        r_wdata <= bus.wdata;
                        r_sel   <= bus.sel;
                        r_cnt   <= CNT_LOAD;
                        r_state <= BUSY;
                    end else if (bus.rd_req) begin
                        r_op    <= READ;
                        r_idx   <= bus.addr[2 +: IDX_W];
                        r_cnt   <= CNT_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_commit = (r_state == BUSY) && (r_cnt == '0);

    sp_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_rd_en (w_commit && (r_op == READ)),
        .i_wr_en (w_commit && (r_op == WRITE)),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .i_sel   (r_sel),
        .o_rdata (w_rdata)
    );

    assign bus.rdata    = w_rdata;
    assign bus.bus_full = (r_state != IDLE);
    assign bus.ack      = (r_state == RESP);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-array model.
module tb_bus_mem_responder;
    import mem_bus_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    resp_state_t dbg_state;

    bus_mem_responder_if bus ();

    bus_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] wd,
                                        input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[word_of(a)][8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the responder idle; returns at the negedge after bus_full falls.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s, input string tag);
        bus.rd_req = rd;
        bus.wr_req = wr;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.sel    = s;
        if (wr) model_write(a, wd, s);
        else if (rd) exp_q.push_back(ref_mem[word_of(a)]);
        @(posedge clk);
        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        for (int j = 0; j <= LAT; j++) begin
            check_val({tag, ":busy"}, 32'(bus.bus_full), 32'd1);
            check_val({tag, ":ack"}, 32'(bus.ack), 32'(j == LAT));
            if (j == LAT && rd && !wr) ref_rdata = exp_q.pop_front();
            check_val({tag, ":rdata"}, bus.rdata, ref_rdata);
            if (j < LAT) @(negedge clk);
        end
        @(negedge clk);
        check_val({tag, ":idle_full"}, 32'(bus.bus_full), 32'd0);
        check_val({tag, ":idle_ack"}, 32'(bus.ack), 32'd0);
        check_val({tag, ":idle_rdata"}, bus.rdata, ref_rdata);
    endtask

    // Read request held high across two transactions: second accept right after IDLE.
    task automatic held_read(input logic [31:0] a);
        bus.rd_req = 1'b1;
        bus.addr   = a;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j <= 2 * LAT + 2; j++) begin
            check_val("held:ack", 32'(bus.ack), 32'((j == LAT) || (j == 2 * LAT + 2)));
            check_val("held:busy", 32'(bus.bus_full), 32'(j != LAT + 1));
            if (j == LAT) ref_rdata = ref_mem[word_of(a)];
            check_val("held:rdata", bus.rdata, ref_rdata);
            if (j == 2 * LAT + 2) bus.rd_req = 1'b0;
            @(negedge clk);
        end
        check_val("held:idle", 32'(bus.bus_full), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.sel    = '0;
        ref_rdata  = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b1;
        #1;
        check_val("reset:rdata", bus.rdata, 32'h0);
        check_val("reset:full", 32'(bus.bus_full), 32'd0);
        check_val("reset:ack", 32'(bus.ack), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd10");
        check_val("rd10:value", ref_rdata, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, "preset0");
        do_req(1'b0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, "be_wr");
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "be_rd");
        check_val("be:value", bus.rdata, 32'h11BB33DD);

        do_req(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, "both");
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "both_rd");
        check_val("both:value", bus.rdata, 32'h5);

        do_req(1'b0, 1'b1, 32'h400, 32'hCAFE, 4'hF, "wrap_wr");
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "wrap_rd");
        check_val("wrap:value", bus.rdata, 32'hCAFE);

        // Asynchronous reset pulse between clock edges.
        rst = 1'b1;
        #1;
        ref_rdata = '0;
        check_val("async_rst:rdata", bus.rdata, 32'h0);
        check_val("async_rst:full", 32'(bus.bus_full), 32'd0);
        check_val("async_rst:ack", 32'(bus.ack), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset one cycle after a write is accepted aborts it.
        do_req(1'b0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, "pre8");
        bus.wr_req = 1'b1;
        bus.addr   = 32'h8;
        bus.wdata  = 32'h1234;
        bus.sel    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.wr_req = 1'b0;
        rst = 1'b1;
        #1;
        check_val("abort:full", 32'(bus.bus_full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < LAT + 2; j++) begin
            check_val("abort:ack", 32'(bus.ack), 32'd0);
            check_val("abort:rdata", bus.rdata, 32'h0);
            @(negedge clk);
        end
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, "abort_rd");
        check_val("abort:value", bus.rdata, 32'h0BADF00D);

        held_read(32'h10);

        // Randomized traffic over 16 words, random upper and low-order address bits.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 1'b1, ($urandom() & 32'hFFFF_FC00) | 32'(i << 2), $urandom(), 4'hF, "rnd_init");
        end
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2)
                | 32'($urandom_range(0, 3));
            case (kind)
                0:       do_req(1'b1, 1'b0, a, $urandom(), 4'($urandom_range(0, 15)), "rnd_rd");
                1:       do_req(1'b0, 1'b1, a, $urandom(), 4'($urandom_range(0, 15)), "rnd_wr");
                default: do_req(1'b1, 1'b1, a, $urandom(), 4'($urandom_range(0, 15)), "rnd_both");
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
